// File: rtl/init_port_if.sv
// Initiator-side parallel handshake and serial bus lanes of the initiator bus port.
// The port itself uses the slave view; the initiator/arbiter/target side uses master.
`timescale 1ns/1ps
interface init_port_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  init_req;
    logic [ADDR_WIDTH-1:0] init_addr_in;
    logic                  init_addr_in_valid;
    logic [DATA_WIDTH-1:0] init_data_in;
    logic                  init_data_in_valid;
    logic                  init_rw;
    logic                  init_ready;
    logic                  init_grant;
    logic                  init_ack;
    logic                  init_split_ack;
    logic [DATA_WIDTH-1:0] init_data_out;
    logic                  init_data_out_valid;
    logic                  bus_req;
    logic                  bus_grant;
    logic                  bus_addr_out;
    logic                  bus_addr_out_valid;
    logic                  bus_data_out;
    logic                  bus_data_out_valid;
    logic                  bus_rw;
    logic                  bus_rdata_in;
    logic                  bus_rdata_in_valid;
    logic                  bus_ack;
    logic                  bus_split;

    modport master (
        output init_req, init_addr_in, init_addr_in_valid, init_data_in,
               init_data_in_valid, init_rw, init_ready,
               bus_grant, bus_rdata_in, bus_rdata_in_valid, bus_ack, bus_split,
        input  init_grant, init_ack, init_split_ack, init_data_out, init_data_out_valid,
               bus_req, bus_addr_out, bus_addr_out_valid, bus_data_out,
               bus_data_out_valid, bus_rw
    );

    modport slave (
        input  init_req, init_addr_in, init_addr_in_valid, init_data_in,
               init_data_in_valid, init_rw, init_ready,
               bus_grant, bus_rdata_in, bus_rdata_in_valid, bus_ack, bus_split,
        output init_grant, init_ack, init_split_ack, init_data_out, init_data_out_valid,
               bus_req, bus_addr_out, bus_addr_out_valid, bus_data_out,
               bus_data_out_valid, bus_rw
    );
endinterface

// File: rtl/init_port.sv
// Initiator bus port: requests the serial bus, captures one transaction, shifts it out
// LSB-first and returns the target's acknowledge, split response or read byte.
`timescale 1ns/1ps
module init_port #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    init_port_if.slave port
);
    localparam int CNT_W = $clog2(ADDR_WIDTH + 1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, CAPTURE, SHIFT, WAIT_RESP, SPLIT, RX, RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cap;
    logic [ADDR_WIDTH-1:0] addr_sr;
    logic [ADDR_WIDTH-1:0] addr_now;
    logic [DATA_WIDTH-1:0] data_cap;
    logic [DATA_WIDTH-1:0] data_sr;
    logic [DATA_WIDTH-1:0] data_now;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic [DATA_WIDTH-1:0] rx_next;
    logic                  addr_got;
    logic                  data_got;
    logic                  cap_done;
    logic [CNT_W-1:0]      cnt;

    // Address and data may arrive in different cycles of the capture window;
    // the value presented in the closing cycle is used directly so the first
    // serial bit can go out on that same edge.
    always_comb begin
        addr_now = port.init_addr_in_valid ? port.init_addr_in : addr_cap;
        data_now = (port.init_rw && port.init_data_in_valid) ? port.init_data_in : data_cap;
        cap_done = (addr_got || port.init_addr_in_valid) &&
                   (!port.init_rw || data_got || port.init_data_in_valid);
        rx_next                 = rx_sr >> 1;
        rx_next[DATA_WIDTH-1]   = port.bus_rdata_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                    <= IDLE;
            addr_cap                 <= '0;
            addr_sr                  <= '0;
            data_cap                 <= '0;
            data_sr                  <= '0;
            rx_sr                    <= '0;
            addr_got                 <= 1'b0;
            data_got                 <= 1'b0;
            cnt                      <= '0;
            port.init_grant          <= 1'b0;
            port.init_ack            <= 1'b0;
            port.init_split_ack      <= 1'b0;
            port.init_data_out       <= '0;
            port.init_data_out_valid <= 1'b0;
            port.bus_req             <= 1'b0;
            port.bus_addr_out        <= 1'b0;
            port.bus_addr_out_valid  <= 1'b0;
            port.bus_data_out        <= 1'b0;
            port.bus_data_out_valid  <= 1'b0;
            port.bus_rw              <= 1'b1;
        end else begin
            port.init_ack            <= 1'b0;
            port.init_split_ack      <= 1'b0;
            port.init_data_out_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (port.init_req) begin
                        port.bus_req <= 1'b1;
                        state        <= REQ;
                    end
                end

                REQ: begin
                    if (port.bus_grant) begin
                        port.init_grant <= 1'b1;
                        addr_got        <= 1'b0;
                        data_got        <= 1'b0;
                        state           <= CAPTURE;
                    end else if (!port.init_req) begin
                        port.bus_req <= 1'b0;
                        state        <= IDLE;
                    end
                end

                CAPTURE: begin
                    port.bus_rw <= port.init_rw;
                    if (port.init_addr_in_valid) begin
                        addr_cap <= port.init_addr_in;
                        addr_got <= 1'b1;
                    end
                    if (port.init_rw && port.init_data_in_valid) begin
                        data_cap <= port.init_data_in;
                        data_got <= 1'b1;
                    end
                    if (cap_done) begin
                        port.init_grant         <= 1'b0;
                        cnt                     <= '0;
                        port.bus_addr_out       <= addr_now[0];
                        port.bus_addr_out_valid <= 1'b1;
                        addr_sr                 <= addr_now >> 1;
                        port.bus_data_out       <= port.init_rw & data_now[0];
                        port.bus_data_out_valid <= port.init_rw;
                        data_sr                 <= data_now >> 1;
                        state                   <= SHIFT;
                    end
                end

                // cnt is the index of the bit currently on the lanes; bus_grant is not
                // consulted here so a mid-shift grant drop cannot truncate the frame.
                SHIFT: begin
                    if (cnt == ADDR_LAST) begin
                        port.bus_addr_out       <= 1'b0;
                        port.bus_addr_out_valid <= 1'b0;
                        port.bus_data_out       <= 1'b0;
                        port.bus_data_out_valid <= 1'b0;
                        state                   <= WAIT_RESP;
                    end else begin
                        cnt               <= cnt + 1'b1;
                        port.bus_addr_out <= addr_sr[0];
                        addr_sr           <= addr_sr >> 1;
                        if (port.bus_rw && cnt < DATA_LAST) begin
                            port.bus_data_out       <= data_sr[0];
                            port.bus_data_out_valid <= 1'b1;
                            data_sr                 <= data_sr >> 1;
                        end else begin
                            port.bus_data_out       <= 1'b0;
                            port.bus_data_out_valid <= 1'b0;
                        end
                    end
                end

                WAIT_RESP: begin
                    if (port.bus_rw) begin
                        if (port.bus_ack) begin
                            port.init_ack <= 1'b1;
                            port.bus_req  <= 1'b0;
                            state         <= IDLE;
                        end else if (port.bus_split) begin
                            port.init_split_ack <= 1'b1;
                            port.bus_req        <= 1'b0;
                            state               <= IDLE;
                        end
                    end else if (port.bus_split) begin
                        port.init_split_ack <= 1'b1;
                        port.bus_req        <= 1'b0;
                        state               <= SPLIT;
                    end else if (port.bus_rdata_in_valid) begin
                        rx_sr <= rx_next;
                        cnt   <= CNT_W'(1);
                        state <= RX;
                    end
                end

                SPLIT: begin
                    if (port.bus_rdata_in_valid) begin
                        rx_sr <= rx_next;
                        cnt   <= CNT_W'(1);
                        state <= RX;
                    end
                end

                RX: begin
                    if (port.bus_rdata_in_valid) begin
                        rx_sr <= rx_next;
                        cnt   <= cnt + 1'b1;
                        if (cnt == DATA_LAST) begin
                            port.init_data_out <= rx_next;
                            state              <= RESP;
                        end
                    end
                end

                RESP: begin
                    if (port.init_ready) begin
                        port.init_ack            <= 1'b1;
                        port.init_data_out_valid <= 1'b1;
                        port.bus_req             <= 1'b0;
                        state                    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_init_port.sv
// Bench for init_port: directed vector table, hand-written reset/withdrawal sequences
// and randomized transactions checked against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_init_port;
    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    init_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();
    init_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .port(ifc.slave));

    // resp: 0 = ack, 1 = split, 2 = write: ack+split together / read: stray ack before data
    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            grant_dly;
        int            late;
        int            resp;
        int            gap;
        int            split_wait;
        int            ready_dly;
        int            abort_at;
        int            exp_ack;
        int            exp_split;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [AW-1:0] aw;
        int            acnt;
        logic [DW-1:0] dw;
        int            dcnt;
        int            ack;
        int            split;
        int            rvalid;
        logic [DW-1:0] rdata;
        int            resp_lat;
    } res_t;

    int n_cmp = 0;
    int n_fail = 0;
    int m_ack, m_split, m_rvalid, m_vld_noack, m_rw_err;
    logic [DW-1:0] m_rdata;
    logic rw_chk = 1'b0;
    logic rw_exp = 1'b1;
    int o_req_first, o_grant_lat, o_cap_cyc, o_first_valid, o_req_after;
    int o_early_grant, o_split_now, o_split_req;
    res_t obs;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (ifc.init_ack) m_ack++;
        if (ifc.init_split_ack) m_split++;
        if (ifc.init_data_out_valid) begin
            m_rvalid++;
            m_rdata = ifc.init_data_out;
            if (!ifc.init_ack) m_vld_noack++;
        end
        if (rw_chk && ifc.bus_rw !== rw_exp) m_rw_err++;
    endtask

    task automatic idle_inputs();
        ifc.init_req = 0;           ifc.init_addr_in = '0;  ifc.init_addr_in_valid = 0;
        ifc.init_data_in = '0;      ifc.init_data_in_valid = 0;
        ifc.init_rw = 0;            ifc.init_ready = 0;     ifc.bus_grant = 0;
        ifc.bus_rdata_in = 0;       ifc.bus_rdata_in_valid = 0;
        ifc.bus_ack = 0;            ifc.bus_split = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ctl"}, {ifc.init_grant, ifc.init_ack, ifc.init_split_ack, ifc.init_data_out_valid,
                            ifc.bus_req, ifc.bus_addr_out, ifc.bus_addr_out_valid, ifc.bus_data_out,
                            ifc.bus_data_out_valid, ifc.bus_rw}, 32'h001);
        chk({tag, "_dout"}, ifc.init_data_out, 0);
    endtask

    function automatic vec_t mkv(logic rw, logic [AW-1:0] addr, logic [DW-1:0] data, int gd, int late,
                                 int resp, int gap, int sw, int rd, int ea, int es, logic [DW-1:0] er);
        vec_t v;
        v.rw = rw; v.addr = addr; v.data = data; v.grant_dly = gd; v.late = late; v.resp = resp;
        v.gap = gap; v.split_wait = sw; v.ready_dly = rd; v.abort_at = -1;
        v.exp_ack = ea; v.exp_split = es; v.exp_rdata = er;
        return v;
    endfunction

    // What one transaction should look like from outside, straight from the protocol rules.
    function automatic res_t model(vec_t v);
        res_t e;
        e.aw       = v.addr;
        e.acnt     = AW;
        e.dw       = v.rw ? v.data : '0;
        e.dcnt     = v.rw ? DW : 0;
        e.ack      = (v.rw && v.resp == 1) ? 0 : 1;
        e.split    = (v.resp == 1) ? 1 : 0;
        e.rvalid   = v.rw ? 0 : 1;
        e.rdata    = v.rw ? '0 : v.data;
        e.resp_lat = v.rw ? 1 : v.ready_dly + 1;
        return e;
    endfunction

    task automatic run_txn(input vec_t v);
        int guard;
        m_ack = 0; m_split = 0; m_rvalid = 0; m_vld_noack = 0; m_rw_err = 0; m_rdata = '0;
        obs.aw = '0; obs.acnt = 0; obs.dw = '0; obs.dcnt = 0; obs.ack = 0; obs.split = 0;
        obs.rvalid = 0; obs.rdata = '0; obs.resp_lat = 0;
        o_early_grant = 0; o_split_now = 0; o_split_req = 1;
        rw_chk = 0; rw_exp = v.rw;

        ifc.init_req = 1; ifc.init_rw = v.rw; ifc.init_addr_in = v.addr; ifc.init_data_in = v.data;
        ifc.init_addr_in_valid = 0; ifc.init_data_in_valid = 0; ifc.init_ready = 0;
        step();
        o_req_first = ifc.bus_req;
        repeat (v.grant_dly) begin
            step();
            if (ifc.init_grant) o_early_grant++;
        end
        ifc.bus_grant = 1;
        o_grant_lat = 0;
        do begin
            step();
            o_grant_lat++;
        end while (!ifc.init_grant && o_grant_lat < 10);

        o_cap_cyc = 0;
        do begin
            ifc.init_addr_in_valid = 1;
            ifc.init_data_in_valid = v.rw && (o_cap_cyc >= v.late);
            step();
            o_cap_cyc++;
        end while (ifc.init_grant && o_cap_cyc < 10);

        // Everything on the initiator side is now scrambled or withdrawn; none of it may matter.
        ifc.init_addr_in_valid = 0; ifc.init_data_in_valid = 0; ifc.init_req = 0; ifc.bus_grant = 0;
        ifc.init_addr_in = ~v.addr; ifc.init_data_in = ~v.data; ifc.init_rw = ~v.rw;
        rw_chk = 1;
        o_first_valid = ifc.bus_addr_out_valid;
        guard = 0;
        while (ifc.bus_addr_out_valid && guard < 40) begin
            if (v.abort_at >= 0 && obs.acnt == v.abort_at) begin
                rw_chk = 0;
                #2 rst = 1;
                #1 chk_reset("mid_shift_rst");
                idle_inputs();
                step();
                step();
                rst = 0;
                step();
                return;
            end
            if (obs.acnt < AW) obs.aw[obs.acnt] = ifc.bus_addr_out;
            if (ifc.bus_data_out_valid) begin
                if (obs.acnt < DW) obs.dw[obs.acnt] = ifc.bus_data_out;
                obs.dcnt++;
            end
            obs.acnt++;
            step();
            guard++;
        end

        if (v.rw) begin
            ifc.bus_ack = (v.resp != 1); ifc.bus_split = (v.resp != 0);
            do begin
                step();
                obs.resp_lat++;
                ifc.bus_ack = 0; ifc.bus_split = 0;
            end while (!(ifc.init_ack || ifc.init_split_ack) && obs.resp_lat < 5);
        end else begin
            if (v.resp == 2) begin
                ifc.bus_ack = 1; step(); ifc.bus_ack = 0;
            end
            if (v.resp == 1) begin
                ifc.bus_split = 1; step(); ifc.bus_split = 0;
                o_split_now = ifc.init_split_ack;
                o_split_req = ifc.bus_req;
                repeat (v.split_wait) step();
            end
            for (int i = 0; i < DW; i++) begin
                if (i > 0) begin
                    repeat (v.gap) begin
                        ifc.bus_rdata_in = 1'($urandom_range(0, 1));
                        step();
                    end
                end
                ifc.bus_rdata_in_valid = 1; ifc.bus_rdata_in = v.data[i];
                step();
                ifc.bus_rdata_in_valid = 0; ifc.bus_rdata_in = 1'($urandom_range(0, 1));
            end
            do begin
                if (obs.resp_lat == v.ready_dly) ifc.init_ready = 1;
                step();
                obs.resp_lat++;
            end while (!ifc.init_ack && obs.resp_lat < v.ready_dly + 6);
            ifc.init_ready = 0;
        end
        o_req_after = ifc.bus_req;
        rw_chk = 0;
        obs.ack = m_ack; obs.split = m_split; obs.rvalid = m_rvalid; obs.rdata = m_rdata;
    endtask

    task automatic check_txn(input string tag, input vec_t v, input res_t e);
        chk({tag, "_bus_req"}, o_req_first, 1);
        chk({tag, "_early_grant"}, o_early_grant, 0);
        chk({tag, "_grant_lat"}, o_grant_lat, 1);
        chk({tag, "_cap_cycles"}, o_cap_cyc, v.rw ? v.late + 1 : 1);
        chk({tag, "_first_bit"}, o_first_valid, 1);
        chk({tag, "_addr_bits"}, obs.acnt, e.acnt);
        chk({tag, "_addr_lane"}, obs.aw, e.aw);
        chk({tag, "_data_bits"}, obs.dcnt, e.dcnt);
        if (v.rw) chk({tag, "_data_lane"}, obs.dw, e.dw);
        chk({tag, "_acks"}, obs.ack, e.ack);
        chk({tag, "_splits"}, obs.split, e.split);
        chk({tag, "_rvalids"}, obs.rvalid, e.rvalid);
        if (!v.rw) chk({tag, "_rdata"}, obs.rdata, e.rdata);
        chk({tag, "_resp_lat"}, obs.resp_lat, e.resp_lat);
        chk({tag, "_req_after"}, o_req_after, 0);
        chk({tag, "_rw_stable"}, m_rw_err, 0);
        chk({tag, "_rvalid_wo_ack"}, m_vld_noack, 0);
        if (!v.rw && v.resp == 1) begin
            chk({tag, "_split_pulse"}, o_split_now, 1);
            chk({tag, "_split_req"}, o_split_req, 0);
        end
    endtask

    vec_t vecs[6];
    vec_t v;
    res_t e;

    initial begin
        //                rw  addr      data   gd late resp gap sw  rd  ack split rdata
        vecs[0] = mkv(1, 16'h0012, 8'hAA, 2, 0, 0, 0, 0, 0, 1, 0, 8'h00);
        vecs[1] = mkv(0, 16'h0034, 8'h5C, 0, 0, 0, 0, 0, 0, 1, 0, 8'h5C);
        vecs[2] = mkv(0, 16'h00F0, 8'hC3, 1, 0, 1, 1, 20, 0, 1, 1, 8'hC3);
        vecs[3] = mkv(1, 16'hBEEF, 8'h3C, 0, 2, 2, 0, 0, 0, 1, 0, 8'h00);
        vecs[4] = mkv(1, 16'h8001, 8'hFF, 3, 1, 1, 0, 0, 0, 0, 1, 8'h00);
        vecs[5] = mkv(0, 16'hFFFF, 8'h81, 0, 0, 2, 2, 0, 3, 1, 0, 8'h81);

        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1 chk_reset("reset");
        rst = 0;
        step();

        foreach (vecs[i]) begin
            run_txn(vecs[i]);
            e = model(vecs[i]);
            e.ack = vecs[i].exp_ack;
            e.split = vecs[i].exp_split;
            e.rdata = vecs[i].exp_rdata;
            check_txn($sformatf("vec%0d", i), vecs[i], e);
        end

        // Withdrawal before grant, then a late grant that must be ignored in IDLE.
        idle_inputs();
        step();
        ifc.init_req = 1;
        step();
        chk("withdraw_req_up", ifc.bus_req, 1);
        ifc.init_req = 0;
        step();
        chk("withdraw_req_down", ifc.bus_req, 0);
        chk("withdraw_no_grant", ifc.init_grant, 0);
        ifc.bus_grant = 1;
        step();
        chk("withdraw_idle_grant", ifc.init_grant, 0);
        chk("withdraw_idle_req", ifc.bus_req, 0);
        ifc.bus_grant = 0;
        step();

        // Reset while bit 5 is on the wire, then a normal write.
        v = mkv(1, 16'h1234, 8'h5A, 1, 0, 0, 0, 0, 0, 1, 0, 8'h00);
        v.abort_at = 5;
        run_txn(v);
        chk("abort_no_resp", m_ack + m_split, 0);
        v = mkv(1, 16'h0012, 8'hAA, 0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
        run_txn(v);
        check_txn("after_rst", v, model(v));

        for (int t = 0; t < 30; t++) begin
            v = mkv(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 25)), int'($urandom_range(0, 3)),
                    0, 0, 8'h00);
            run_txn(v);
            check_txn($sformatf("rnd%0d", t), v, model(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
